// File: rtl/dsp_pkg.sv
// ---------------------------------------------------------------------------
// dsp_pkg
// Shared declarations for the dsp_add family of blocks.
//   reduce_state_t : state encoding of the streaming reduction controller
//                    (RUN = accumulating beats, DONE = holding a result)
//   DSP_MAX_WIDTH  : widest datapath the dsp_add primitive supports
// ---------------------------------------------------------------------------
package dsp_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DONE = 1'b1
  } reduce_state_t;

  localparam int DSP_MAX_WIDTH = 48;

endpackage

// File: rtl/dsp_add.sv
// ---------------------------------------------------------------------------
// dsp_add
// Unsigned adder primitive with an optional output register.
// Ports:
//   clock  in   1      clock for the optional output register
//   reset  in   1      asynchronous, active-high reset of the output register
//   a      in   width  first operand
//   b      in   width  second operand
//   y      out  width  a + b modulo 2^width (registered when PREG=1)
// ---------------------------------------------------------------------------
module dsp_add
  import dsp_pkg::*;
#(
  parameter int width = 48,
  parameter bit PREG  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] y
);

  logic [width-1:0] sum_comb;
  logic [width-1:0] sum_reg;

  if (width < 1 || width > DSP_MAX_WIDTH) begin : g_bad_width
    $error("dsp_add: width out of range");
  end

  assign sum_comb = a + b;

  // The register always exists; PREG only decides which copy reaches y,
  // so with PREG=0 it is simply left for synthesis to trim.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_reg <= '0;
    end else begin
      sum_reg <= sum_comb;
    end
  end

  assign y = PREG ? sum_reg : sum_comb;

endmodule

// File: rtl/dsp_add_reduce.sv
// ---------------------------------------------------------------------------
// dsp_add_reduce
// Streaming reduction controller: sums every beat of an in_last-delimited
// group into an accumulator and emits one result per group.
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      beat accepted this cycle (high while accumulating)
//   in_data    in   WIDTH  unsigned operand
//   in_last    in   1      final beat of the group
//   out_valid  out  1      result valid (high while holding a result)
//   out_ready  in   1      consumer accepts the result
//   out_data   out  WIDTH  group sum modulo 2^WIDTH
//   out_count  out  LEN_W  number of terms, saturating at all-ones
//   out_ovf    out  1      some addition in the group carried out
// ---------------------------------------------------------------------------
module dsp_add_reduce
  import dsp_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LEN_W-1:0] out_count,
  output logic             out_ovf
);

  reduce_state_t    state;
  reduce_state_t    state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_sat;
  logic             ovf;
  logic             carry;
  logic             accept;

  if (WIDTH < 1 || WIDTH > DSP_MAX_WIDTH || LEN_W < 1) begin : g_bad_params
    $error("dsp_add_reduce: WIDTH must be 1..DSP_MAX_WIDTH and LEN_W >= 1");
  end

  // The primitive resets active-high; its register is bypassed, so the
  // inversion only keeps the hookup honest.
  dsp_add #(
    .width(WIDTH)
  ) u_add (
    .clock(clock),
    .reset(~reset),
    .a    (acc),
    .b    (in_data),
    .y    (sum)
  );

  // A wrapped unsigned sum is always smaller than the operand it started from.
  assign carry   = (sum < acc);
  assign cnt_sat = (cnt == '1) ? cnt : cnt + LEN_W'(1);
  assign accept  = in_valid & in_ready;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs: accept beats in RUN, offer the
  // result in DONE until the consumer takes it.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Accumulator, term counter and overflow flag; the result registers
  // capture the final values on the last beat, and the running state is
  // cleared once the result has been handed off.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt_sat;
      ovf <= ovf | carry;
      if (in_last) begin
        out_data  <= sum;
        out_count <= cnt_sat;
        out_ovf   <= ovf | carry;
      end
    end else if (state == DONE && out_ready) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsp_add_reduce.sv
// ---------------------------------------------------------------------------
// tb_dsp_add_reduce
// Directed bench for dsp_add_reduce. Instance 0 is WIDTH=48/LEN_W=8,
// instance 1 is WIDTH=8/LEN_W=2; both share clock and reset.
// ---------------------------------------------------------------------------
module tb_dsp_add_reduce;

  typedef struct {
    int          sel;
    int          n;
    logic [47:0] beats [6];
    logic [47:0] exp_data;
    logic [7:0]  exp_count;
    logic        exp_ovf;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [1:0]  in_valid;
  logic [1:0]  in_last;
  logic [1:0]  out_ready;
  logic [47:0] in_data [2];
  logic [1:0]  in_ready;
  logic [1:0]  out_valid;
  logic [47:0] out_data48;
  logic [7:0]  out_data8;
  logic [7:0]  out_count8b;
  logic [1:0]  out_count2b;
  logic [1:0]  out_ovf;

  int   checks;
  int   errors;
  vec_t vecs [$];

  dsp_add_reduce #(.WIDTH(48), .LEN_W(8)) dut_w48 (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .in_data  (in_data[0]),
    .in_last  (in_last[0]),
    .out_valid(out_valid[0]),
    .out_ready(out_ready[0]),
    .out_data (out_data48),
    .out_count(out_count8b),
    .out_ovf  (out_ovf[0])
  );

  dsp_add_reduce #(.WIDTH(8), .LEN_W(2)) dut_w8 (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .in_data  (in_data[1][7:0]),
    .in_last  (in_last[1]),
    .out_valid(out_valid[1]),
    .out_ready(out_ready[1]),
    .out_data (out_data8),
    .out_count(out_count2b),
    .out_ovf  (out_ovf[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [47:0] get_data(input int sel);
    return (sel == 1) ? {40'd0, out_data8} : out_data48;
  endfunction

  function automatic logic [7:0] get_count(input int sel);
    return (sel == 1) ? {6'd0, out_count2b} : out_count8b;
  endfunction

  task automatic check_val(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int sel, input int n,
                         input logic [47:0] b0, input logic [47:0] b1,
                         input logic [47:0] b2, input logic [47:0] b3,
                         input logic [47:0] b4,
                         input logic [47:0] ed, input logic [7:0] ec, input logic eo);
    vec_t v;
    v.sel = sel;
    v.n   = n;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2;
    v.beats[3] = b3; v.beats[4] = b4; v.beats[5] = '0;
    v.exp_data  = ed;
    v.exp_count = ec;
    v.exp_ovf   = eo;
    vecs.push_back(v);
  endtask

  // Wait (bounded) until the selected instance is ready for a beat.
  task automatic wait_ready(input int sel);
    int budget = 0;
    while (!in_ready[sel] && budget < 20) begin
      @(posedge clock);
      #1;
      budget++;
    end
    if (!in_ready[sel]) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: in_ready[%0d] got 0, expected 1", sel);
    end
  endtask

  // Drive all beats of a vector back-to-back; close=0 leaves the group open.
  task automatic apply_stimulus(input vec_t v, input bit close);
    for (int i = 0; i < v.n; i++) begin
      in_valid[v.sel] = 1'b1;
      in_data[v.sel]  = v.beats[i];
      in_last[v.sel]  = close && (i == v.n - 1);
      wait_ready(v.sel);
      @(posedge clock);
      #1;
    end
    in_valid[v.sel] = 1'b0;
    in_last[v.sel]  = 1'b0;
  endtask

  // Called one cycle after the last beat: result must already be valid.
  task automatic check_output(input vec_t v, input string tag);
    check_val({tag, "_out_valid"}, {47'd0, out_valid[v.sel]}, 48'd1);
    check_val({tag, "_out_data"}, get_data(v.sel), v.exp_data);
    check_val({tag, "_out_count"}, {40'd0, get_count(v.sel)}, {40'd0, v.exp_count});
    check_val({tag, "_out_ovf"}, {47'd0, out_ovf[v.sel]}, {47'd0, v.exp_ovf});
    out_ready[v.sel] = 1'b1;
    @(posedge clock);
    #1;
    out_ready[v.sel] = 1'b0;
    check_val({tag, "_valid_after_hs"}, {47'd0, out_valid[v.sel]}, 48'd0);
    check_val({tag, "_ready_after_hs"}, {47'd0, in_ready[v.sel]}, 48'd1);
  endtask

  initial begin
    vec_t v;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = '0;
    in_data[0] = '0;
    in_data[1] = '0;

    add_vec(0, 3, 48'd3, 48'd5, 48'd7, 48'd0, 48'd0, 48'd15, 8'd3, 1'b0);
    add_vec(0, 1, 48'h2A, 48'd0, 48'd0, 48'd0, 48'd0, 48'h2A, 8'd1, 1'b0);
    add_vec(0, 2, 48'd1, 48'd1, 48'd0, 48'd0, 48'd0, 48'd2, 8'd2, 1'b0);
    add_vec(0, 2, 48'hFFFF_FFFF_FFFF, 48'd2, 48'd0, 48'd0, 48'd0, 48'd1, 8'd2, 1'b1);
    add_vec(1, 2, 48'd200, 48'd100, 48'd0, 48'd0, 48'd0, 48'd44, 8'd2, 1'b1);
    add_vec(1, 1, 48'd10, 48'd0, 48'd0, 48'd0, 48'd0, 48'd10, 8'd1, 1'b0);
    add_vec(1, 5, 48'd1, 48'd1, 48'd1, 48'd1, 48'd1, 48'd5, 8'd3, 1'b0);
    add_vec(1, 3, 48'd1, 48'd2, 48'd3, 48'd0, 48'd0, 48'd6, 8'd3, 1'b0);

    repeat (2) @(posedge clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      check_val("reset_in_ready", {47'd0, in_ready[s]}, 48'd1);
      check_val("reset_out_valid", {47'd0, out_valid[s]}, 48'd0);
      check_val("reset_out_data", get_data(s), 48'd0);
      check_val("reset_out_count", {40'd0, get_count(s)}, 48'd0);
      check_val("reset_out_ovf", {47'd0, out_ovf[s]}, 48'd0);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i], 1'b1);
      check_output(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held while a new beat waits on the input.
    v = vecs[0];
    v.n = 2; v.beats[0] = 48'd10; v.beats[1] = 48'd20;
    apply_stimulus(v, 1'b1);
    in_valid[0] = 1'b1;
    in_data[0]  = 48'd99;
    in_last[0]  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check_val("bp_in_ready", {47'd0, in_ready[0]}, 48'd0);
      check_val("bp_out_valid", {47'd0, out_valid[0]}, 48'd1);
      check_val("bp_out_data", out_data48, 48'd30);
      check_val("bp_out_count", {40'd0, out_count8b}, 48'd2);
      @(posedge clock);
      #1;
    end
    out_ready[0] = 1'b1;
    @(posedge clock);
    #1;
    out_ready[0] = 1'b0;
    check_val("bp_release_valid", {47'd0, out_valid[0]}, 48'd0);
    check_val("bp_release_ready", {47'd0, in_ready[0]}, 48'd1);
    @(posedge clock);
    #1;
    in_valid[0] = 1'b0;
    in_last[0]  = 1'b0;
    v.beats[0] = 48'd99; v.exp_data = 48'd99; v.exp_count = 8'd1; v.exp_ovf = 1'b0;
    check_output(v, "bp_next");

    // Asynchronous reset in the middle of a group.
    v.n = 2; v.beats[0] = 48'd4; v.beats[1] = 48'd9;
    apply_stimulus(v, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_val("rst_out_valid", {47'd0, out_valid[0]}, 48'd0);
    check_val("rst_out_data", out_data48, 48'd0);
    check_val("rst_out_count", {40'd0, out_count8b}, 48'd0);
    check_val("rst_in_ready", {47'd0, in_ready[0]}, 48'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      check_val("rst_hold_valid", {47'd0, out_valid[0]}, 48'd0);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    v.n = 1; v.beats[0] = 48'd6; v.exp_data = 48'd6; v.exp_count = 8'd1; v.exp_ovf = 1'b0;
    apply_stimulus(v, 1'b1);
    check_output(v, "rst_next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
